ub_mem_responder: RTL

UB_MEM_RESPONDER -- requirements
Module: ub_mem_responder

---
 rtl/ub_mem_responder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ub_mem_responder.sv
// ub_mem_responder
// Single-port word memory with two request paths. The compute side has a
// fixed-latency read pipeline and absolute priority. The host side uses a
// ready handshake for preload and readback and is served only in cycles the
// compute side leaves idle. Out-of-range accesses return zero, drop writes and
// raise a sticky error flag.
module ub_mem_responder #(
    parameter int DATA_WIDTH     = 32,
    parameter int BANKING_FACTOR = 1,
    parameter int ADDRESS_WIDTH  = 13,
    parameter int DEPTH          = 8192,
    parameter int MEM_LATENCY    = 3
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [ADDRESS_WIDTH-1:0]               mem_req_addr,
    input  logic [BANKING_FACTOR*DATA_WIDTH-1:0]   mem_req_data,
    input  logic                                   mem_read_en,
    input  logic                                   mem_write_en,
    output logic [BANKING_FACTOR*DATA_WIDTH-1:0]   mem_resp_data,
    output logic                                   mem_resp_valid,
    input  logic [ADDRESS_WIDTH-1:0]               host_addr,
    input  logic [BANKING_FACTOR*DATA_WIDTH-1:0]   host_wdata,
    input  logic                                   host_write_en,
    input  logic                                   host_read_en,
    output logic                                   host_ready,
    output logic [BANKING_FACTOR*DATA_WIDTH-1:0]   host_rdata,
    output logic                                   host_rvalid,
    output logic                                   err_addr
);

    localparam int W      = BANKING_FACTOR * DATA_WIDTH;
    // Register stages between the request and mem_resp_data; the first stage
    // captures the array word, the last stage is the output register itself.
    localparam int STAGES = MEM_LATENCY - 1;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDRESS_WIDTH is representable.
    localparam logic [ADDRESS_WIDTH:0] DEPTH_V = (ADDRESS_WIDTH + 1)'(DEPTH);

    // Storage; lane b of a word lives in bits [b*DATA_WIDTH +: DATA_WIDTH].
    logic [W-1:0] mem [DEPTH];

    logic             cmp_in_range;
    logic             host_in_range;
    logic [IDX_W-1:0] cmp_idx;
    logic [IDX_W-1:0] host_idx;
    logic [W-1:0]     cmp_rd_word;
    logic [W-1:0]     host_rd_word;
    logic             host_accept_rd;
    logic             host_accept_wr;
    logic             cmp_err;
    logic             host_err;

    logic             mem_we;
    logic [IDX_W-1:0] mem_widx;
    logic [W-1:0]     mem_wdata;

    logic [STAGES-1:0] pipe_vld;
    logic [W-1:0]      pipe_data [STAGES];

    // Address decode, host arbitration and the shared write port.
    always_comb begin
        cmp_in_range   = ({1'b0, mem_req_addr} < DEPTH_V);
        host_in_range  = ({1'b0, host_addr} < DEPTH_V);
        cmp_idx        = mem_req_addr[IDX_W-1:0];
        host_idx       = host_addr[IDX_W-1:0];
        cmp_rd_word    = cmp_in_range ? mem[cmp_idx] : '0;
        host_rd_word   = host_in_range ? mem[host_idx] : '0;

        // Compute traffic always wins; the host simply waits.
        host_ready     = ~(mem_read_en | mem_write_en);
        host_accept_rd = host_ready & host_read_en;
        host_accept_wr = host_ready & host_write_en;

        cmp_err  = (mem_read_en | mem_write_en) & ~cmp_in_range;
        host_err = (host_accept_rd | host_accept_wr) & ~host_in_range;

        // Only one side can write in a cycle because the host is locked out
        // whenever the compute side is active. Writes are suppressed while
        // reset is asserted.
        mem_we    = 1'b0;
        mem_widx  = cmp_idx;
        mem_wdata = mem_req_data;
        if (mem_write_en) begin
            mem_we = rst_n & cmp_in_range;
        end else if (host_accept_wr) begin
            mem_we    = rst_n & host_in_range;
            mem_widx  = host_idx;
            mem_wdata = host_wdata;
        end
    end

    // Array write; reads in the same cycle see the pre-write word.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    // Compute read pipeline; each data stage holds until a new beat arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < STAGES; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= mem_read_en;
            if (mem_read_en) begin
                pipe_data[0] <= cmp_rd_word;
            end
            for (int i = 1; i < STAGES; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

    assign mem_resp_data  = pipe_data[STAGES-1];
    assign mem_resp_valid = pipe_vld[STAGES-1];

    // Host readback with one cycle of latency; data holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            host_rvalid <= host_accept_rd;
            if (host_accept_rd) begin
                host_rdata <= host_rd_word;
            end
        end
    end

    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr <= 1'b0;
        end else if (cmp_err | host_err) begin
            err_addr <= 1'b1;
        end
    end

endmodule
